// File: rtl/vlsu_axi_throttle.sv
// ---------------------------------------------------------------------------
// vlsu_axi_throttle
//
// Purpose:
//   Sits between the vector load/store unit AXI master port and the memory
//   interconnect. Limits outstanding read bursts (AR issued, last R beat not
//   yet seen) and write bursts (AW issued, B not yet seen). Provides a
//   flush/drain handshake so the dispatcher can wait for all vector memory
//   traffic to retire before a fence or scalar access.
//   All channels pass through combinationally. Only the AR/AW valid/ready
//   pairs are gated. The outstanding counters and the drain FSM are registered.
//
// Ports:
//   clk_i              clock
//   rst_i              synchronous active-high reset
//   slv_req_i          requests from the load/store unit
//   slv_resp_o         responses to the load/store unit
//   mst_req_o          requests to memory
//   mst_resp_i         responses from memory
//   flush_req_i        start a drain (sampled only in RUN)
//   flush_ack_o        one-cycle pulse when the drain completes
//   rd_outstanding_o   outstanding read bursts
//   wr_outstanding_o   outstanding write bursts
//   idle_o             nothing outstanding and FSM in RUN
//   error_o            sticky counter underflow flag (cleared by reset only)
//   stall_rd_cycles_o  cycles an AR was presented while blocked
//   stall_wr_cycles_o  cycles an AW was presented while blocked
//
// Optional feature macro: VLSU_AXI_THROTTLE_STATS_EN
//   Defined   : stall counters are present and saturate at 32'hFFFF_FFFF.
//   Undefined : stall outputs are tied to 0 and no counter flops exist.
// ---------------------------------------------------------------------------

// Default AXI channel types. The top module takes the request/response types
// as type parameters, so an integrating design can pass its own structs as
// long as they use the same field names.
package vlsu_axi_throttle_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ax_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;

endpackage

// ---------------------------------------------------------------------------
// vlsu_axi_throttle_cnt
//
// Purpose:
//   Saturating-at-zero outstanding-burst counter shared by the read and the
//   write side.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   inc_i          burst issued (address handshake on the master side)
//   dec_i          burst completed (last R beat / B handshake)
//   cnt_o          registered count
//   cnt_next_o     count after this cycle's events
//   full_o         registered count equals Max
//   underflow_o    completion seen with nothing outstanding
// ---------------------------------------------------------------------------
module vlsu_axi_throttle_cnt #(
    parameter int unsigned Max = 8,
    parameter int unsigned W   = $clog2(Max + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_next_o,
    output logic         full_o,
    output logic         underflow_o
);

    logic [W-1:0] cnt_q;

    // Simultaneous issue and completion cancel out. A completion with
    // nothing outstanding holds the count at zero and is reported instead.
    always_comb begin
        cnt_next_o  = cnt_q;
        underflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            cnt_next_o = cnt_q + W'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                cnt_next_o = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next_o;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q == W'(Max));

endmodule

// ---------------------------------------------------------------------------
// vlsu_axi_throttle (top)
// ---------------------------------------------------------------------------
module vlsu_axi_throttle #(
    parameter type         axi_req_t  = vlsu_axi_throttle_pkg::axi_req_t,
    parameter type         axi_resp_t = vlsu_axi_throttle_pkg::axi_resp_t,
    parameter int unsigned MaxRdTxns  = 8,
    parameter int unsigned MaxWrTxns  = 8,
    parameter int unsigned RdCntW     = $clog2(MaxRdTxns + 1),
    parameter int unsigned WrCntW     = $clog2(MaxWrTxns + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  axi_req_t          slv_req_i,
    output axi_resp_t         slv_resp_o,
    output axi_req_t          mst_req_o,
    input  axi_resp_t         mst_resp_i,
    input  logic              flush_req_i,
    output logic              flush_ack_o,
    output logic [RdCntW-1:0] rd_outstanding_o,
    output logic [WrCntW-1:0] wr_outstanding_o,
    output logic              idle_o,
    output logic              error_o,
    output logic [31:0]       stall_rd_cycles_o,
    output logic [31:0]       stall_wr_cycles_o
);

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StDrain = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0] state_q, state_d;

    logic [RdCntW-1:0] rd_cnt, rd_cnt_next;
    logic [WrCntW-1:0] wr_cnt, wr_cnt_next;
    logic              rd_full, wr_full;
    logic              rd_underflow, wr_underflow;
    logic              rd_inc, rd_dec, wr_inc, wr_dec;
    logic              ar_block, aw_block;
    logic              error_q;

    // Gating looks only at registered state, so a completion at the limit
    // frees the slot for the following cycle, never the same one.
    assign ar_block = rd_full || (state_q != StRun);
    assign aw_block = wr_full || (state_q != StRun);

    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.ar_valid  = slv_req_i.ar_valid && !ar_block;
        mst_req_o.aw_valid  = slv_req_i.aw_valid && !aw_block;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && !ar_block;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && !aw_block;
    end

    // Issue is counted on the gated master-side handshake. Reads retire on
    // the last R beat; W beats are never tracked because W may lead AW.
    assign rd_inc = mst_req_o.ar_valid && mst_resp_i.ar_ready;
    assign rd_dec = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
    assign wr_inc = mst_req_o.aw_valid && mst_resp_i.aw_ready;
    assign wr_dec = mst_resp_i.b_valid && slv_req_i.b_ready;

    vlsu_axi_throttle_cnt #(
        .Max (MaxRdTxns),
        .W   (RdCntW)
    ) i_rd_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (rd_inc),
        .dec_i       (rd_dec),
        .cnt_o       (rd_cnt),
        .cnt_next_o  (rd_cnt_next),
        .full_o      (rd_full),
        .underflow_o (rd_underflow)
    );

    vlsu_axi_throttle_cnt #(
        .Max (MaxWrTxns),
        .W   (WrCntW)
    ) i_wr_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (wr_inc),
        .dec_i       (wr_dec),
        .cnt_o       (wr_cnt),
        .cnt_next_o  (wr_cnt_next),
        .full_o      (wr_full),
        .underflow_o (wr_underflow)
    );

    // Drain FSM. DRAIN exits on the post-update counts so the cycle carrying
    // the final completion is the last DRAIN cycle; with nothing outstanding
    // on entry DRAIN lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (flush_req_i) state_d = StDrain;
            end
            StDrain: begin
                if ((rd_cnt_next == '0) && (wr_cnt_next == '0)) state_d = StDone;
            end
            StDone: begin
                state_d = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rd_underflow || wr_underflow) error_q <= 1'b1;
        end
    end

    assign flush_ack_o      = (state_q == StDone);
    assign rd_outstanding_o = rd_cnt;
    assign wr_outstanding_o = wr_cnt;
    assign idle_o           = (rd_cnt == '0) && (wr_cnt == '0) && (state_q == StRun);
    assign error_o          = error_q;

`ifdef VLSU_AXI_THROTTLE_STATS_EN
    logic [31:0] stall_rd_q, stall_wr_q;

    // Counts cycles where the LSU presents an address the throttle holds off.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_rd_q <= '0;
            stall_wr_q <= '0;
        end else begin
            if (slv_req_i.ar_valid && ar_block && (stall_rd_q != 32'hFFFF_FFFF)) begin
                stall_rd_q <= stall_rd_q + 32'd1;
            end
            if (slv_req_i.aw_valid && aw_block && (stall_wr_q != 32'hFFFF_FFFF)) begin
                stall_wr_q <= stall_wr_q + 32'd1;
            end
        end
    end

    assign stall_rd_cycles_o = stall_rd_q;
    assign stall_wr_cycles_o = stall_wr_q;
`else
    assign stall_rd_cycles_o = 32'd0;
    assign stall_wr_cycles_o = 32'd0;
`endif

endmodule
